// File: rtl/vga_timing_counter_if.sv
// VGA timing bundle: run enable in, pixel strobe,
// raster counters, line/frame pulses and sync out.
interface vga_timing_counter_if;
  logic       en;
  logic       pix_en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       new_line;
  logic       new_frame;
  logic       h_sync;
  logic       video_on;

  modport master (
    input  en,
    output pix_en,
    output h_count,
    output v_count,
    output new_line,
    output new_frame,
    output h_sync,
    output video_on
  );

  modport slave (
    output en,
    input  pix_en,
    input  h_count,
    input  v_count,
    input  new_line,
    input  new_frame,
    input  h_sync,
    input  video_on
  );
endinterface

// File: rtl/vga_timing_counter.sv
// VGA raster timing: pixel divider, h/v counters,
// horizontal region FSM, registered h_sync.
module vga_timing_counter #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BACK   = 48,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input logic             clk,
  input logic             rst,
  vga_timing_counter_if.master bus
);
  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_PULSE + H_BACK;

  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);
  localparam logic [9:0] ACT_LAST =
    10'(H_ACTIVE - 1);
  localparam logic [9:0] FP_LAST =
    10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] SYN_LAST =
    10'(H_ACTIVE + H_FRONT + H_PULSE - 1);
  localparam logic [9:0] V_VIS =
    10'(V_ACTIVE);
  localparam logic [3:0] DIV_LAST =
    4'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    H_ACT,
    H_FP,
    H_SYN,
    H_BP
  } h_state_t;

  h_state_t   state;
  h_state_t   state_next;
  logic [3:0] div;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_sync;
  logic       tick;
  logic       h_wrap;
  logic       pix_out;
  logic       line_out;

  assign tick   = bus.en & (div == DIV_LAST);
  assign h_wrap = h_count == H_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (bus.en) begin
      div <= (div == DIV_LAST) ? '0 : div + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (tick) begin
      h_count <= h_wrap ? '0 : h_count + 10'd1;
      if (h_wrap) begin
        v_count <= (v_count == V_LAST) ?
                   '0 : v_count + 10'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      unique case (state)
        H_ACT:
          if (h_count == ACT_LAST) state_next = H_FP;
        H_FP:
          if (h_count == FP_LAST) state_next = H_SYN;
        H_SYN:
          if (h_count == SYN_LAST) state_next = H_BP;
        H_BP:
          if (h_wrap) state_next = H_ACT;
      endcase
    end
  end

  // h_sync is registered off state_next so it moves
  // on the same edge as h_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= H_ACT;
      h_sync <= 1'b1;
    end else begin
      state  <= state_next;
      h_sync <= state_next != H_SYN;
    end
  end

  // With CLK_DIV=1 the divider already matches in reset,
  // so the strobe is masked until rst releases.
  assign pix_out  = tick & rst;
  assign line_out = pix_out & h_wrap;

  assign bus.pix_en    = pix_out;
  assign bus.h_count   = h_count;
  assign bus.v_count   = v_count;
  assign bus.new_line  = line_out;
  assign bus.new_frame = line_out & (v_count == V_LAST);
  assign bus.h_sync    = h_sync;
  assign bus.video_on  = (state == H_ACT) &
                         (v_count < V_VIS);
endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench: default 800x525 timing plus a tiny
// CLK_DIV=1 raster for whole-frame behaviour.
module tb_vga_timing_counter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  vga_timing_counter_if bus();
  vga_timing_counter_if bus_s();

  vga_timing_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vga_timing_counter #(
    .CLK_DIV  (1),
    .H_ACTIVE (8),
    .H_FRONT  (2),
    .H_PULSE  (3),
    .H_BACK   (1),
    .V_TOTAL  (4),
    .V_ACTIVE (3)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [9:0] h;
    logic [9:0] v;
    logic       pix;
    logic       nl;
    logic       nf;
    logic       hs;
    logic       vo;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [24:0] pk(vec_t e);
    return {e.h, e.v, e.pix, e.nl, e.nf, e.hs, e.vo};
  endfunction

  function automatic logic [24:0] obs_d();
    return {bus.h_count, bus.v_count, bus.pix_en,
            bus.new_line, bus.new_frame,
            bus.h_sync, bus.video_on};
  endfunction

  function automatic logic [24:0] obs_s();
    return {bus_s.h_count, bus_s.v_count,
            bus_s.pix_en, bus_s.new_line,
            bus_s.new_frame, bus_s.h_sync,
            bus_s.video_on};
  endfunction

  function automatic logic [24:0] mk(
    int h, int v, logic pix, logic nl,
    logic nf, logic hs, logic vo);
    return {10'(h), 10'(v), pix, nl, nf, hs, vo};
  endfunction

  task automatic check(input string name,
                       input logic [24:0] act,
                       input logic [24:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display(
        "FAIL %s: got h=%0d v=%0d pix/nl/nf/hs/vo=%b, want h=%0d v=%0d pix/nl/nf/hs/vo=%b",
        name, act[24:15], act[14:5], act[4:0],
        exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic check_int(input string name,
                           input int act,
                           input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, exp);
    end
  endtask

  initial begin
    int k;
    int nl_cnt, nl_last, nl_gap;
    int pix_cnt, hs_low, vo_hi;
    int nf_cnt, nf_last, nf_gap;
    int eh, ev;
    logic enl, enf, ehs, evo;

    n_tests = 0;
    n_fail  = 0;

    // k = clk edges since reset release, en=1
    tbl[0]  = '{0,    0,   0, 0, 0, 0, 1, 1};
    tbl[1]  = '{1,    0,   0, 1, 0, 0, 1, 1};
    tbl[2]  = '{2,    1,   0, 0, 0, 0, 1, 1};
    tbl[3]  = '{1279, 639, 0, 1, 0, 0, 1, 1};
    tbl[4]  = '{1280, 640, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{1311, 655, 0, 1, 0, 0, 1, 0};
    tbl[6]  = '{1312, 656, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1503, 751, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1504, 752, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1599, 799, 0, 1, 1, 0, 1, 0};
    tbl[10] = '{1600, 0,   1, 0, 0, 0, 1, 1};
    tbl[11] = '{1601, 0,   1, 1, 0, 0, 1, 1};
    tbl[12] = '{3199, 799, 1, 1, 1, 0, 1, 0};
    tbl[13] = '{3200, 0,   2, 0, 0, 0, 1, 1};

    rst      = 1'b1;
    bus.en   = 1'b1;
    bus_s.en = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("reset_async",
          obs_d(), mk(0, 0, 0, 0, 0, 1, 1));
    check("reset_div1_pix_masked",
          obs_s(), mk(0, 0, 0, 0, 0, 1, 1));
    repeat (2) @(posedge clk);
    #2;
    check("reset_held",
          obs_d(), mk(0, 0, 0, 0, 0, 1, 1));
    check("reset_held_div1",
          obs_s(), mk(0, 0, 0, 0, 0, 1, 1));

    @(posedge clk);
    #2;
    rst      = 1'b1;
    bus_s.en = 1'b0;
    k = 0;
    foreach (tbl[i]) begin
      if (tbl[i].k > k) begin
        repeat (tbl[i].k - k) @(posedge clk);
        #2;
        k = tbl[i].k;
      end
      check($sformatf("vec_k%0d", tbl[i].k),
            obs_d(), pk(tbl[i]));
    end

    nl_cnt  = 0;
    nl_last = 0;
    nl_gap  = 0;
    pix_cnt = 0;
    hs_low  = 0;
    vo_hi   = 0;
    for (int i = 1; i <= 3200; i++) begin
      @(posedge clk);
      #2;
      if (bus.new_line) begin
        if (nl_cnt > 0) nl_gap = i - nl_last;
        nl_last = i;
        nl_cnt++;
      end
      if (bus.pix_en) pix_cnt++;
      if (!bus.h_sync) hs_low++;
      if (bus.video_on) vo_hi++;
    end
    k = 6400;
    check_int("new_line_count", nl_cnt, 2);
    check_int("new_line_period", nl_gap, 1600);
    check_int("pix_en_count", pix_cnt, 1600);
    check_int("h_sync_low_clks", hs_low, 384);
    check_int("video_on_clks", vo_hi, 2560);

    repeat (7711 - k) @(posedge clk);
    #2;
    check("at_655",
          obs_d(), mk(655, 4, 1, 0, 0, 1, 0));
    bus.en = 1'b0;
    #1;
    check("en_drop_strobe",
          obs_d(), mk(655, 4, 0, 0, 0, 1, 0));
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("frozen_%0d", i),
            obs_d(), mk(655, 4, 0, 0, 0, 1, 0));
    end
    bus.en = 1'b1;
    #1;
    check("resume_strobe",
          obs_d(), mk(655, 4, 1, 0, 0, 1, 0));
    @(posedge clk);
    #2;
    check("resume_sync_fall",
          obs_d(), mk(656, 4, 0, 0, 0, 0, 0));

    repeat (88) @(posedge clk);
    #2;
    check("at_700",
          obs_d(), mk(700, 4, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    check("midline_reset",
          obs_d(), mk(0, 0, 0, 0, 0, 1, 1));
    repeat (3) @(posedge clk);
    #2;
    check("midline_reset_held",
          obs_d(), mk(0, 0, 0, 0, 0, 1, 1));
    rst = 1'b1;
    #1;
    check("release_k0",
          obs_d(), mk(0, 0, 0, 0, 0, 1, 1));
    @(posedge clk);
    #1;
    check("release_k1",
          obs_d(), mk(0, 0, 1, 0, 0, 1, 1));
    @(posedge clk);
    #1;
    check("release_k2",
          obs_d(), mk(1, 0, 0, 0, 0, 1, 1));

    #1;
    bus_s.en = 1'b1;
    #1;
    nl_cnt  = 0;
    nl_last = 0;
    nl_gap  = 0;
    nf_cnt  = 0;
    nf_last = 0;
    nf_gap  = 0;
    for (int j = 0; j <= 112; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #2;
      end
      eh  = j % 14;
      ev  = (j / 14) % 4;
      enl = eh == 13;
      enf = enl && ev == 3;
      ehs = !(eh >= 10 && eh <= 12);
      evo = eh < 8 && ev < 3;
      check($sformatf("small_j%0d", j), obs_s(),
            mk(eh, ev, 1'b1, enl, enf, ehs, evo));
      if (bus_s.new_line) begin
        if (nl_cnt > 0) nl_gap = j - nl_last;
        nl_last = j;
        nl_cnt++;
      end
      if (bus_s.new_frame) begin
        if (nf_cnt > 0) nf_gap = j - nf_last;
        nf_last = j;
        nf_cnt++;
      end
    end
    check_int("small_line_count", nl_cnt, 8);
    check_int("small_line_period", nl_gap, 14);
    check_int("small_frame_count", nf_cnt, 2);
    check_int("small_frame_period", nf_gap, 56);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_counter.md
VGA_TIMING_COUNTER -- requirements
Module: vga_timing_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, system clocks per pixel (legal 1..16).
REQ-002 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-004 SHALL have parameter H_PULSE, default 96, horizontal sync width in pixels.
REQ-005 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-006 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-007 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-008 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-009 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port en  input  1  run enable; low freezes all counters and the divider.
REQ-011 SHALL have port pix_en  output  1  one-clk pixel strobe.
REQ-012 SHALL have port h_count  output  10  pixel index in line, 0..H_TOTAL-1.
REQ-013 SHALL have port v_count  output  10  line index in frame, 0..V_TOTAL-1.
REQ-014 SHALL have port new_line  output  1  one-clk end-of-line pulse for the vertical sync stage.
REQ-015 SHALL have port new_frame  output  1  one-clk end-of-frame pulse.
REQ-016 SHALL have port h_sync  output  1  horizontal sync, active-low.
REQ-017 SHALL have port video_on  output  1  high while (h_count, v_count) is in the visible area.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_PULSE+H_BACK (default 800); all compares SHALL be unsigned, 10-bit.
REQ-019 Divider SHALL count 0..CLK_DIV-1 while en=1; pix_en SHALL be high exactly in the clk cycle where divider = CLK_DIV-1; CLK_DIV=1 SHALL give pix_en=en.
REQ-020 h_count SHALL increment on each clk edge with pix_en=1 and wrap from H_TOTAL-1 to 0.
REQ-021 v_count SHALL increment only on the edge where h_count wraps, and wrap from V_TOTAL-1 to 0 on that same edge.
REQ-022 new_line SHALL be high for exactly the one clk cycle with pix_en=1 and h_count=H_TOTAL-1; v_count SHALL still hold the old line value during that cycle.
REQ-023 new_frame SHALL be high exactly when new_line=1 and v_count=V_TOTAL-1.
REQ-024 A horizontal state machine SHALL track regions: H_ACT (h 0..H_ACTIVE-1), H_FP, H_SYN, H_BP; it SHALL advance only on pix_en edges at region boundaries, H_BP returning to H_ACT on h_count wrap.
REQ-025 h_sync SHALL be registered, low exactly while state is H_SYN (default h_count 656..751), aligned to the same edge as h_count.
REQ-026 video_on SHALL be high iff state is H_ACT and v_count < V_ACTIVE.
REQ-027 With en=0, divider, h_count, v_count, state and h_sync SHALL hold; pix_en, new_line and new_frame SHALL be 0.
REQ-028 All outputs SHALL be derived from registers only; no combinational path from en to outputs other than the gating in REQ-027.

Reset
REQ-029 While rst=0: divider=0, h_count=0, v_count=0, state=H_ACT, h_sync=1, pix_en=0, new_line=0, new_frame=0, video_on=1.
REQ-030 Reset assertion mid-line or mid-frame SHALL take effect immediately without waiting for clk; no partial pulse SHALL follow release.
REQ-031 After rst rises, the first pix_en SHALL occur CLK_DIV clk edges later with en=1.

Verification
REQ-032 Defaults, en=1, reset released -> pix_en every 2nd clk; h_count wraps 799->0; new_line period 1600 clk, width 1 clk.
REQ-033 Run one line -> h_sync low for 96 pixels starting at h_count=656; video_on high for h_count 0..639 only.
REQ-034 Run full frame -> v_count 0..524 then 0; new_frame single pulse with v_count=524, h_count=799; video_on low for all v_count>=480.
REQ-035 Drop en for 7 clk at h_count=655 -> all counters frozen, no strobes; resume -> h_sync falls at next pix_en with h_count=656.
REQ-036 Assert rst at h_count=700, v_count=300 -> outputs per REQ-029 within the same cycle; release -> counting restarts from 0,0.
REQ-037 CLK_DIV=1, H_ACTIVE=8, H_FRONT=2, H_PULSE=3, H_BACK=1, V_TOTAL=4, V_ACTIVE=3 -> new_line every 14 clk, new_frame every 56 clk.
